// File: rtl/data_mem_mp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_mp
// Description : W x 2**A data memory, one write port, NRD read ports,
//               optional registered read, hardware init sweep on reset/Clear.
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_mp #(
    parameter int              W        = 8,
    parameter int              A        = 8,
    parameter int              NRD      = 2,
    parameter int              RD_REG   = 0,
    parameter logic [W-1:0]    INIT_VAL = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Clear,
    output logic               Busy,
    input  logic               WriteEn,
    input  logic [A-1:0]       WrAddr,
    input  logic [W-1:0]       DataIn,
    input  logic [NRD*A-1:0]   RdAddr,
    output logic [NRD*W-1:0]   RdData
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic [A-1:0]   r_ptr;
    logic           r_busy;

    logic [W-1:0]   r_core [0:(2**A)-1];

    logic           w_wr;
    logic           w_mem_we;
    logic [A-1:0]   w_mem_addr;
    logic [W-1:0]   w_mem_data;

    // A user write landing on a Clear edge is dropped, including its bypass.
    assign w_wr       = (r_state == S_RUN) && WriteEn && !Clear;
    assign w_mem_we   = (r_state == S_INIT) || w_wr;
    assign w_mem_addr = (r_state == S_INIT) ? r_ptr : WrAddr;
    assign w_mem_data = (r_state == S_INIT) ? INIT_VAL : DataIn;
    assign Busy       = r_busy;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else if (Clear) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == {A{1'b1}}) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= S_INIT;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // The array carries no reset; the sweep is what initialises it.
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_core[w_mem_addr] <= w_mem_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [A-1:0] w_raddr;
            logic [W-1:0] w_rdata;

            assign w_raddr = RdAddr[gi*A +: A];
            assign w_rdata = r_core[w_raddr];

            if (RD_REG == 0) begin : g_comb
                assign RdData[gi*W +: W] = r_busy ? INIT_VAL : w_rdata;
            end else begin : g_reg
                logic [W-1:0] r_rd;

                always_ff @(posedge Clk or negedge Reset) begin
                    if (!Reset) begin
                        r_rd <= '0;
                    end else if (r_busy) begin
                        r_rd <= INIT_VAL;
                    end else if (w_wr && (w_raddr == WrAddr)) begin
                        r_rd <= DataIn;
                    end else begin
                        r_rd <= w_rdata;
                    end
                end

                assign RdData[gi*W +: W] = r_rd;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_mp
// Description : Scoreboard bench for data_mem_mp, combinational and
//               registered read variants driven side by side.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_mp;

    localparam int          c_W    = 8;
    localparam int          c_A    = 4;
    localparam int          c_NRD  = 2;
    localparam logic [7:0]  c_INIT = 8'hA5;

    localparam int K_B0   = 0;
    localparam int K_B1   = 1;
    localparam int K_R0P0 = 2;
    localparam int K_R0P1 = 3;
    localparam int K_R1P0 = 4;
    localparam int K_R1P1 = 5;

    logic                   Clk;
    logic                   Reset;
    logic                   Clear;
    logic                   WriteEn;
    logic [c_A-1:0]         WrAddr;
    logic [c_W-1:0]         DataIn;
    logic [c_NRD*c_A-1:0]   RdAddr;
    logic                   w_busy0;
    logic                   w_busy1;
    logic [c_NRD*c_W-1:0]   w_rd0;
    logic [c_NRD*c_W-1:0]   w_rd1;

    data_mem_mp #(.W(c_W), .A(c_A), .NRD(c_NRD), .RD_REG(0), .INIT_VAL(c_INIT)) u_dut_comb (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .Busy(w_busy0),
        .WriteEn(WriteEn), .WrAddr(WrAddr), .DataIn(DataIn),
        .RdAddr(RdAddr), .RdData(w_rd0)
    );

    data_mem_mp #(.W(c_W), .A(c_A), .NRD(c_NRD), .RD_REG(1), .INIT_VAL(c_INIT)) u_dut_reg (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .Busy(w_busy1),
        .WriteEn(WriteEn), .WrAddr(WrAddr), .DataIn(DataIn),
        .RdAddr(RdAddr), .RdData(w_rd1)
    );

    typedef struct {
        int         tag;
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] actual(input int kind);
        case (kind)
            K_B0:    return {7'd0, w_busy0};
            K_B1:    return {7'd0, w_busy1};
            K_R0P0:  return w_rd0[7:0];
            K_R0P1:  return w_rd0[15:8];
            K_R1P0:  return w_rd1[7:0];
            default: return w_rd1[15:8];
        endcase
    endfunction

    // Monitor: every negedge, retire the expectations tagged for this cycle.
    always @(negedge Clk) begin
        int i;
        logic [7:0] v;
        i = 0;
        while (i < q.size()) begin
            if (q[i].tag == edge_cnt) begin
                v = actual(q[i].kind);
                checks = checks + 1;
                if (v !== q[i].exp) begin
                    errors = errors + 1;
                    $display("FAIL %s: got %02h expected %02h (cycle %0d)",
                             q[i].name, v, q[i].exp, edge_cnt);
                end
                q.delete(i);
            end else if (q[i].tag < edge_cnt) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s: never sampled (tag %0d)", q[i].name, q[i].tag);
                q.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic push(input int dt, input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.tag  = edge_cnt + dt;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Caller positions itself on the first Busy cycle; returns on the first RUN cycle.
    task automatic sweep_check(input string nm);
        for (int i = 0; i < 16; i++) begin
            RdAddr = {4'(15 - i), 4'(i)};
            push(0, K_B0, 8'd1, {nm, "_busy0"});
            push(0, K_B1, 8'd1, {nm, "_busy1"});
            push(0, K_R0P0, c_INIT, {nm, "_rd0_busyval"});
            if (i > 0) push(0, K_R1P1, c_INIT, {nm, "_rd1_busyval"});
            step();
        end
        push(0, K_B0, 8'd0, {nm, "_busy0_fall"});
        push(0, K_B1, 8'd0, {nm, "_busy1_fall"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, limit 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset   = 1'b0;
        Clear   = 1'b0;
        WriteEn = 1'b0;
        WrAddr  = '0;
        DataIn  = '0;
        RdAddr  = '0;

        step();
        push(0, K_B0, 8'd1, "rst_busy0");
        push(0, K_B1, 8'd1, "rst_busy1");
        push(0, K_R1P0, 8'h00, "rst_rd1p0");
        push(0, K_R1P1, 8'h00, "rst_rd1p1");
        step();

        Reset = 1'b1;
        sweep_check("init");

        for (int a = 0; a < 16; a++) begin
            RdAddr = {4'(15 - a), 4'(a)};
            push(0, K_R0P0, c_INIT, "init_rd0p0");
            push(0, K_R0P1, c_INIT, "init_rd0p1");
            push(1, K_R1P0, c_INIT, "init_rd1p0");
            step();
        end

        WriteEn = 1'b1; WrAddr = 4'd5; DataIn = 8'h3C; RdAddr = {4'd5, 4'd5};
        push(0, K_R0P0, c_INIT, "rd0_old5_p0");
        push(0, K_R0P1, c_INIT, "rd0_old5_p1");
        push(1, K_R1P0, 8'h3C, "rd1_bypass5_p0");
        push(1, K_R1P1, 8'h3C, "rd1_bypass5_p1");
        step();
        WriteEn = 1'b0;
        push(0, K_R0P0, 8'h3C, "rd0_new5_p0");
        push(0, K_R0P1, 8'h3C, "rd0_new5_p1");
        push(1, K_R1P0, 8'h3C, "rd1_stored5");
        step();

        WriteEn = 1'b1; WrAddr = 4'd9; DataIn = 8'h77; RdAddr = {4'd2, 4'd9};
        push(0, K_R0P0, c_INIT, "rd0_old9");
        push(1, K_R1P0, 8'h77, "rd1_bypass9");
        push(1, K_R1P1, c_INIT, "rd1_p1_addr2");
        step();
        WriteEn = 1'b0;
        push(0, K_R0P0, 8'h77, "rd0_new9");
        step();

        WriteEn = 1'b1; WrAddr = 4'd3; DataIn = 8'h11;
        step();
        WriteEn = 1'b0; RdAddr = {4'd9, 4'd3};
        push(0, K_R0P0, 8'h11, "rd0_wr3");
        push(0, K_R0P1, 8'h77, "rd0_keep9");
        step();

        // Clear with a write on the same edge: write and its bypass are dropped.
        Clear = 1'b1; WriteEn = 1'b1; WrAddr = 4'd7; DataIn = 8'hEE; RdAddr = {4'd7, 4'd3};
        push(0, K_B0, 8'd0, "busy_pre_clear");
        push(0, K_R0P1, c_INIT, "rd0_clear7_old");
        push(1, K_R1P0, 8'h11, "rd1_clear3");
        push(1, K_R1P1, c_INIT, "rd1_clear_discard");
        step();
        Clear = 1'b0; WriteEn = 1'b1; WrAddr = 4'd3; DataIn = 8'hFF;
        sweep_check("clr");
        WriteEn = 1'b0; RdAddr = {4'd7, 4'd3};
        push(0, K_R0P0, c_INIT, "rd0_after_clear3");
        push(0, K_R0P1, c_INIT, "rd0_after_clear7");
        push(1, K_R1P0, c_INIT, "rd1_after_clear3");
        step();

        Clear = 1'b1;
        step();
        Clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push(0, K_B0, 8'd1, "mid_busy");
            step();
        end
        Clear = 1'b1;
        push(0, K_B0, 8'd1, "mid_busy_clr");
        step();
        Clear = 1'b0;
        sweep_check("clr_mid");

        WriteEn = 1'b1; WrAddr = 4'd9; DataIn = 8'h5A; RdAddr = {4'd9, 4'd9};
        step();
        WriteEn = 1'b0;
        push(0, K_R0P0, 8'h5A, "rd0_pre_rst");
        push(0, K_R1P1, 8'h5A, "rd1_pre_rst");
        step();
        #2;
        Reset = 1'b0;
        #1;
        push(0, K_B0, 8'd1, "async_busy0");
        push(0, K_B1, 8'd1, "async_busy1");
        push(0, K_R1P0, 8'h00, "async_rd1p0");
        push(0, K_R1P1, 8'h00, "async_rd1p1");
        step();
        step();
        Reset = 1'b1;
        sweep_check("post_rst");
        RdAddr = {4'd9, 4'd5};
        push(0, K_R0P0, c_INIT, "post_rst_rd5");
        push(0, K_R0P1, c_INIT, "post_rst_rd9");
        push(1, K_R1P1, c_INIT, "post_rst_rd1_9");
        step();
        step();
        step();

        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_mp.md
Name: data_mem_mp

Overview:
- Parametrised successor to the single-port 8x256 data memory.
- Provides one synchronous write port and NRD independent read ports, with configurable read latency.
- Includes a hardware sweep engine that initialises every word to INIT_VAL after reset or on a Clear request, so the array itself needs no reset.
- Sits between the datapath load/store unit and the register file.

Parameters:
- W, 8: data word width in bits.
- A, 8: address width; depth is 2**A words.
- NRD, 2: number of read ports, 1 to 4.
- RD_REG, 0: read latency. 0 = combinational read; 1 = registered read with one cycle of latency.
- INIT_VAL, 0: W-bit value written to every word by the sweep.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Clear  in  1  one-cycle pulse that restarts the init sweep.
- Busy  out  1  high while the sweep is in progress.
- WriteEn  in  1  write strobe.
- WrAddr  in  A  write address.
- DataIn  in  W  write data.
- RdAddr  in  NRD*A  packed read addresses; port i occupies bits [i*A +: A].
- RdData  out  NRD*W  packed read data; port i occupies bits [i*W +: W].

Behaviour:
- Storage: array core of 2**A words of W bits each. The array is never reset directly.
- FSM states: INIT and RUN. Pointer ptr is A bits wide.
- Reset low (asynchronous): state=INIT, ptr=0, Busy=1. When RD_REG=1, all RdData registers are cleared to 0.
- INIT state:
  - Each rising edge writes INIT_VAL to core[ptr], then increments ptr.
  - On the edge where ptr==2**A-1: the last word is written, ptr wraps to 0, state goes to RUN.
  - Busy is high for exactly 2**A cycles after Reset deasserts.
- RUN state:
  - Busy=0.
  - If WriteEn=1, core[WrAddr] <= DataIn on the rising edge.
- Clear:
  - Sampled on the rising edge in either state.
  - Forces state=INIT, ptr=0 on that edge.
  - Clear during INIT restarts the sweep from address 0.
  - A write presented on the same edge as Clear is discarded.
- While Busy=1:
  - WriteEn is ignored.
  - RdData reads as INIT_VAL on every port, independent of RdAddr. When RD_REG=1 this value appears one cycle later.
- RD_REG=0:
  - RdData[i] = core[RdAddr[i]] combinationally.
  - A read of the address being written in the same cycle returns the old contents; the new data is visible after the edge.
- RD_REG=1:
  - RdData[i] is registered from core[RdAddr[i]]; latency is 1 cycle.
  - Write-first bypass: if WriteEn=1 (in RUN) and RdAddr[i]==WrAddr, the register captures DataIn.
- Read ports are fully independent. Multiple ports may read the same address in the same cycle.
- Address arithmetic: ptr wraps modulo 2**A. Out-of-range addresses cannot occur because all addresses are exactly A bits.
- Reset asserted mid-sweep or mid-write: the current operation aborts immediately; memory contents are undefined until the next sweep completes.

Test Plan:
- Parameters A=4, INIT_VAL=8'hA5, RD_REG=0. Release Reset:
  - Busy stays high for exactly 16 cycles.
  - Then read all 16 addresses: every word is 8'hA5.
- RUN, RD_REG=0:
  - Write 8'h3C to address 5 while port0 reads address 5: port0 shows 8'hA5 in that cycle and 8'h3C on the next cycle.
  - Port1 reading address 5 concurrently shows the same values.
- RD_REG=1:
  - Write 8'h77 to address 9 with RdAddr0=9 in the same cycle: RdData0 is 8'h77 one cycle later (bypass).
  - Port1 reading address 2 shows 8'hA5 one cycle later.
- Write 8'h11 to address 3, then pulse Clear:
  - Busy rises on the next cycle and stays high for 16 cycles.
  - A WriteEn asserted during the sweep has no effect.
  - After Busy falls, address 3 reads 8'hA5.
- Pulse Clear at sweep cycle 7:
  - ptr restarts at 0.
  - Busy stays high for 16 cycles from the Clear edge.
- Assert Reset low mid-RUN, asynchronously between clock edges:
  - Busy goes to 1 immediately, and RdData goes to 0 when RD_REG=1.
  - After release, a full sweep completes.
